// File: rtl/calc_pkg.sv
// calc_pkg: shared state encodings, opcodes and default debounce length for the calculator sequencer
package calc_pkg;
  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_CALC = 2'b10,
    S_RES  = 2'b11
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises a bouncing active-low key and emits one pulse per accepted press
import calc_pkg::*;
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);
  logic s1, s2, acc, acc_d, lvl;
  logic [CNT_W-1:0] cnt;
  assign lvl = ~s2;
  // accepted level resets to pressed so a key held through reset must be released before it can count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      acc <= 1'b1;
      acc_d <= 1'b1;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      acc_d <= acc;
      pulse <= acc & ~acc_d;
      if (lvl == acc) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        acc <= lvl;
        cnt <= '0;
      end else cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: Enter-driven A/B/compute/result sequencer with registered datapath strobes (optional CALC_RESULT_CHAIN_EN)
import calc_pkg::*;
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       enter_n,
  input  logic       addsub_in,
  output logic       a_load,
  output logic       b_load,
  output logic       r_load,
  output logic       ou_load,
  output logic       iu_au,
  output logic       addsub_op,
  output logic [1:0] state_o,
  output logic       a_src
);
`ifdef CALC_RESULT_CHAIN_EN
  localparam logic CHAIN = 1'b1;
  localparam state_t RES_NXT = S_B;
`else
  localparam logic CHAIN = 1'b0;
  localparam state_t RES_NXT = S_A;
`endif
  state_t state, nxt;
  logic enter_pulse;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
    .clk(CLK),
    .rst_n(reset),
    .key_n(enter_n),
    .pulse(enter_pulse)
  );
  assign state_o = state;
  // next state; compute always advances and drops any Enter that lands on it
  always_comb
    nxt = state == S_CALC ? S_RES :
          !enter_pulse    ? state :
          state == S_A    ? S_B   :
          state == S_B    ? S_CALC : RES_NXT;
  // state and all outputs registered so they change together one cycle after the Enter pulse
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      state <= S_A;
      a_load <= 1'b0;
      b_load <= 1'b0;
      r_load <= 1'b0;
      ou_load <= 1'b0;
      iu_au <= 1'b0;
      addsub_op <= OP_ADD;
      a_src <= 1'b0;
    end else begin
      state <= nxt;
      a_load <= enter_pulse && (state == S_A || (CHAIN && state == S_RES));
      b_load <= enter_pulse && state == S_B;
      r_load <= state == S_CALC;
      ou_load <= nxt != S_CALC;
      iu_au <= nxt[1];
      a_src <= CHAIN && enter_pulse && state == S_RES;
      if (enter_pulse && state == S_B) addsub_op <= addsub_in;
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer with a 4-cycle debounce
module tb_calc_sequencer;
  logic CLK = 1'b0, reset = 1'b0, enter_n = 1'b1, addsub_in = 1'b0;
  logic a_load, b_load, r_load, ou_load, iu_au, addsub_op, a_src;
  logic [1:0] state_o;
  int errors = 0, checks = 0;
  int na, nb, nr, multi, first, bad;

  calc_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .enter_n(enter_n), .addsub_in(addsub_in),
    .a_load(a_load), .b_load(b_load), .r_load(r_load), .ou_load(ou_load),
    .iu_au(iu_au), .addsub_op(addsub_op), .state_o(state_o), .a_src(a_src)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    na += int'(a_load);
    nb += int'(b_load);
    nr += int'(r_load);
    if (int'(a_load) + int'(b_load) + int'(r_load) > 1) multi++;
  endtask

  task automatic clr();
    na = 0; nb = 0; nr = 0; multi = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press();
    enter_n = 1'b0;
    idle(12);
    enter_n = 1'b1;
    idle(10);
  endtask

  function automatic int outs();
    return int'({a_load, b_load, r_load, ou_load, iu_au, addsub_op, state_o, a_src});
  endfunction

  initial begin
    clr();
    idle(3);
    chk("reset_outputs", outs(), 0);
    reset = 1'b1;
    idle(10);
    chk("idle_state", int'({ou_load, iu_au, state_o}), 4'b1000);
    chk("idle_no_strobe", na + nb + nr, 0);

    clr();
    for (int i = 0; i < 30; i++) begin
      enter_n = ~enter_n;
      step();
    end
    enter_n = 1'b1;
    idle(10);
    chk("bounce_no_strobe", na + nb + nr, 0);
    chk("bounce_state", int'(state_o), 0);

    clr();
    first = -1;
    enter_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (a_load && first < 0) first = k;
    end
    chk("a_load_latency", first, 7);
    chk("a_load_once", na, 1);
    chk("hold_state_b", int'(state_o), 1);
    enter_n = 1'b1;
    idle(10);
    chk("release_no_strobe", na + nb + nr, 1);

    clr();
    addsub_in = 1'b1;
    enter_n = 1'b0;
    bad = 1;
    for (int k = 0; k < 20 && bad == 1; k++) begin
      step();
      if (b_load) bad = 0;
    end
    chk("b_load_seen", bad, 0);
    chk("b_cycle", int'({addsub_op, state_o, iu_au, ou_load, r_load}), 6'b110100);
    step();
    chk("r_cycle", int'({r_load, b_load, state_o, iu_au, ou_load}), 6'b101111);
    step();
    chk("r_once", int'(r_load), 0);
    enter_n = 1'b1;
    idle(10);
    chk("calc_counts", int'({na[3:0], nb[3:0], nr[3:0]}), 12'h011);
    chk("one_hot_strobes", multi, 0);

    bad = 0;
    for (int i = 0; i < 8; i++) begin
      addsub_in = ~addsub_in;
      step();
      if ({addsub_op, iu_au, ou_load, state_o} !== 5'b11111) bad++;
    end
    chk("res_hold", bad, 0);

    clr();
    first = -1;
    enter_n = 1'b0;
    for (int k = 0; k < 20 && first < 0; k++) begin
      step();
      if (state_o != 2'b11) first = k;
    end
`ifdef CALC_RESULT_CHAIN_EN
    chk("chain_cycle", int'({a_load, a_src, state_o, iu_au, ou_load}), 6'b110101);
    step();
    chk("chain_a_src_clear", int'({a_src, a_load}), 0);
    enter_n = 1'b1;
    idle(10);
`else
    chk("res_to_a", int'({na[1:0], state_o, iu_au, ou_load, a_src}), 7'b0000010);
    enter_n = 1'b1;
    idle(10);
    clr();
    press();
    chk("back_to_b", int'({na[3:0], state_o}), 6'b000101);
`endif

    enter_n = 1'b0;
    bad = 1;
    for (int k = 0; k < 20 && bad == 1; k++) begin
      step();
      if (b_load) bad = 0;
    end
    chk("b_load_before_reset", bad, 0);
    reset = 1'b0;
    #1;
    chk("reset_in_strobe", outs(), 0);
    @(negedge CLK);
    reset = 1'b1;
    chk("state_after_reset", int'(state_o), 0);
    clr();
    idle(15);
    chk("held_key_ignored", int'({na[3:0], state_o}), 0);
    enter_n = 1'b1;
    idle(10);
    clr();
    press();
    chk("repress_a_load", int'({na[3:0], nb[3:0], state_o}), 10'b0001000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
